add8_share_arb: RTL

Round-robin arbiter and two-stage pipeline that shares one combinational 8-bit approximate adder core among NREQ requesters. Each requester offers an operand pair over a valid/ready handshake. The block grants one requester per cycle, registers the operands, computes the 9-bit approximate sum and presents it with the requester index on a single valid/ready result port. It sits between operand producers and the approximate-arithmetic datapath, so one adder instance serves several clients.

---
 rtl/add8_share_arb.sv | 86 ++++++++
 1 files changed

// File: rtl/add8_share_arb.sv
// add8_share_arb: round-robin arbiter feeding one shared 8-bit approximate adder through a two-stage pipeline
// Define ADD8_ERRMON_EN to count cycles where the approximate sum differs from the exact sum.
module add8_share_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [8*NREQ-1:0] req_a,
    input  logic [8*NREQ-1:0] req_b,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [8:0]        res_sum,
    output logic [IDW-1:0]    res_id,
    output logic              busy,
    input  logic              err_clr,
    output logic [15:0]       err_cnt
);
    logic           s1_v, s2_v, adv2, acc1, xfer, c2;
    logic [7:0]     s1_a, s1_b;
    logic [IDW-1:0] s1_id, s2_id, lp, win;
    logic [8:0]     s2_sum, sum;
    assign adv2      = s1_v & (~s2_v | (res_valid & res_ready));
    assign acc1      = rst_n & en & (~s1_v | adv2);
    assign req_ready = acc1 ? NREQ'(1) << win : '0;
    assign xfer      = |(req_ready & req_valid);
    assign res_valid = s2_v;
    assign res_sum   = s2_sum;
    assign res_id    = s2_id;
    assign busy      = s1_v | s2_v;
    // Scan backwards so the closest valid requester after lp is the last one written.
    always_comb begin
        win = IDW'((int'(lp) + 1) % NREQ);
        for (int k = NREQ; k >= 1; k--)
            if (req_valid[(int'(lp) + k) % NREQ]) win = IDW'((int'(lp) + k) % NREQ);
    end
    assign c2  = s1_a[0] & s1_a[1] & s1_b[1] & ~s1_a[6] & ~s1_a[7] & ~s1_b[7];
    assign sum = {7'({1'b0, s1_a[7:2]} + {1'b0, s1_b[7:2]} + {6'b0, c2}), s1_a[1:0] | s1_b[1:0]};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v   <= 1'b0;
            s1_a   <= '0;
            s1_b   <= '0;
            s1_id  <= '0;
            s2_v   <= 1'b0;
            s2_sum <= '0;
            s2_id  <= '0;
            lp     <= IDW'(NREQ - 1);
        end else begin
            if (xfer) begin
                s1_v  <= 1'b1;
                s1_a  <= req_a[8*int'(win) +: 8];
                s1_b  <= req_b[8*int'(win) +: 8];
                s1_id <= win;
                lp    <= win;
            end else if (adv2) begin
                s1_v <= 1'b0;
            end
            if (adv2) begin
                s2_v   <= 1'b1;
                s2_sum <= sum;
                s2_id  <= s1_id;
            end else if (res_ready) begin
                s2_v <= 1'b0;
            end
        end
    end
`ifdef ADD8_ERRMON_EN
    logic [8:0]  exact;
    logic [15:0] cnt;
    assign exact   = {1'b0, s1_a} + {1'b0, s1_b};
    assign err_cnt = cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else if (err_clr) cnt <= '0;
        else if (adv2 && exact != sum && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
    end
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign err_cnt        = '0;
`endif
endmodule
